// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM-bus responder and its word array.
package sram_bus_pkg;

    localparam int         WORD_W  = 32;
    localparam logic [3:0] BE_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    // Overlay the enabled bytes of new_dat onto old_dat (be_n active low).
    function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_dat,
                                                   input logic [WORD_W-1:0] new_dat,
                                                   input logic [3:0]        be_n);
        logic [WORD_W-1:0] r;
        r = old_dat;
        for (int b = 0; b < 4; b++) begin
            if (!be_n[b]) r[b*8 +: 8] = new_dat[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_word_array.sv
// DEPTH x 32 simple dual-port RAM: byte-masked write, one-cycle registered read.
// Read-during-write to the same word returns the old contents.
module sram_word_array
    import sram_bus_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [3:0]        wr_mask_i,
    input  logic [WORD_W-1:0] wr_dat_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [WORD_W-1:0] rd_dat_o
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask_i[b]) mem[wr_addr_i][b*8 +: 8] <= wr_dat_i[b*8 +: 8];
            end
        end
        if (rd_en_i) rd_dat_o <= mem[rd_addr_i];
    end

endmodule

// File: rtl/sram_bus_responder.sv
// Async-SRAM bus responder backed by an internal word array; all bus inputs are
// resampled first, reads return data READ_LAT cycles after the first sampled strobe.
module sram_bus_responder
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int DEPTH    = 4096,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [3:0]        ram_be_n,
    input  logic              ram_ce_n,
    input  logic              ram_oe_n,
    input  logic              ram_we_n,
    input  logic [31:0]       ram_wdata,
    output logic [31:0]       ram_rdata,
    output logic              ram_rdata_oe,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              err_oob
);

    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] s_addr_q;
    logic [3:0]        s_be_n_q;
    logic              s_ce_n_q, s_oe_n_q, s_we_n_q;
    logic [WORD_W-1:0] s_wdata_q;
    logic              s_oob;

    state_e            state_q, state_d;
    logic              wr_latch, wr_commit, rd_issue, rd_done;

    logic [AW-1:0]     pend_addr_q;
    logic [3:0]        pend_be_n_q;
    logic [WORD_W-1:0] pend_dat_q;
    logic              pend_oob_q;

    logic [WORD_W-1:0] ram_dout;
    logic              vld0_q, oob0_q, byp_vld_q;
    logic [3:0]        byp_be_n_q;
    logic [WORD_W-1:0] byp_dat_q;
    logic [WORD_W-1:0] data0, last_dat, hold_q;
    logic              last_vld;

    logic [15:0]       rd_count_q, wr_count_q;
    logic              err_oob_q;

    assign s_oob = ({1'b0, s_addr_q} >= DEPTH_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_addr_q  <= '0;
            s_be_n_q  <= BE_NONE;
            s_ce_n_q  <= 1'b1;
            s_oe_n_q  <= 1'b1;
            s_we_n_q  <= 1'b1;
            s_wdata_q <= '0;
        end else begin
            s_addr_q  <= ram_addr;
            s_be_n_q  <= ram_be_n;
            s_ce_n_q  <= ram_ce_n;
            s_oe_n_q  <= ram_oe_n;
            s_we_n_q  <= ram_we_n;
            s_wdata_q <= ram_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!s_ce_n_q && !s_we_n_q)      state_d = WRITE;
                else if (!s_ce_n_q && !s_oe_n_q) state_d = READ;
            end
            WRITE: begin
                if (s_we_n_q || s_ce_n_q) state_d = (!s_ce_n_q && !s_oe_n_q) ? READ : IDLE;
            end
            READ: begin
                if (!s_ce_n_q && !s_we_n_q)    state_d = WRITE;
                else if (s_ce_n_q || s_oe_n_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_latch  = (state_d == WRITE);
        wr_commit = (state_q == WRITE) && (state_d != WRITE);
        rd_issue  = (state_d == READ);
        rd_done   = (state_q == READ) && (state_d != READ);
    end

    // Pending write tracks the strobe while low; it only reaches the array on the trailing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_addr_q <= '0;
            pend_be_n_q <= BE_NONE;
            pend_dat_q  <= '0;
            pend_oob_q  <= 1'b0;
        end else if (wr_latch) begin
            pend_addr_q <= s_addr_q[AW-1:0];
            pend_be_n_q <= s_be_n_q;
            pend_dat_q  <= s_wdata_q;
            pend_oob_q  <= s_oob;
        end
    end

    sram_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .wr_en_i   (wr_commit && !pend_oob_q),
        .wr_addr_i (pend_addr_q),
        .wr_mask_i (~pend_be_n_q),
        .wr_dat_i  (pend_dat_q),
        .rd_en_i   (rd_issue),
        .rd_addr_i (s_addr_q[AW-1:0]),
        .rd_dat_o  (ram_dout)
    );

    // A read issued on the commit edge of the same word sees old array data, so forward the write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld0_q     <= 1'b0;
            oob0_q     <= 1'b0;
            byp_vld_q  <= 1'b0;
            byp_be_n_q <= BE_NONE;
            byp_dat_q  <= '0;
        end else begin
            vld0_q     <= rd_issue;
            oob0_q     <= s_oob;
            byp_vld_q  <= wr_commit && !pend_oob_q && (pend_addr_q == s_addr_q[AW-1:0]);
            byp_be_n_q <= pend_be_n_q;
            byp_dat_q  <= pend_dat_q;
        end
    end

    assign data0 = oob0_q    ? '0 :
                   byp_vld_q ? be_merge(ram_dout, byp_dat_q, byp_be_n_q) : ram_dout;

    if (READ_LAT == 1) begin : g_direct
        assign last_dat = data0;
        assign last_vld = vld0_q;
    end else begin : g_pipe
        logic [WORD_W-1:0] dat_q [READ_LAT-1];
        logic [READ_LAT-2:0] vld_q;

        // Valid bits are flushed as soon as READ is left so stale data never drives.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < READ_LAT-1; i++) dat_q[i] <= '0;
                vld_q <= '0;
            end else begin
                dat_q[0] <= data0;
                vld_q[0] <= vld0_q && rd_issue;
                for (int i = 1; i < READ_LAT-1; i++) begin
                    dat_q[i] <= dat_q[i-1];
                    vld_q[i] <= vld_q[i-1] && rd_issue;
                end
            end
        end

        assign last_dat = dat_q[READ_LAT-2];
        assign last_vld = vld_q[READ_LAT-2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q     <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_oob_q  <= 1'b0;
        end else begin
            if (last_vld)  hold_q     <= last_dat;
            if (rd_done)   rd_count_q <= rd_count_q + 16'd1;
            if (wr_commit) wr_count_q <= wr_count_q + 16'd1;
            if ((wr_commit && pend_oob_q) || (rd_issue && s_oob)) err_oob_q <= 1'b1;
        end
    end

    assign ram_rdata    = last_vld ? last_dat : hold_q;
    assign ram_rdata_oe = last_vld && (state_q == READ);
    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;
    assign err_oob      = err_oob_q;

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench: three responders (READ_LAT 1, 2, 4) share one bus; each scenario task checks inline.
module tb_sram_bus_responder;

    localparam int ADDR_W = 20;
    localparam int DEPTH  = 4096;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [3:0]        be = 4'hF;
    logic              ce = 1'b1, oe = 1'b1, we = 1'b1;
    logic [31:0]       wdata = '0;

    logic [31:0] rdata1, rdata2, rdata4;
    logic        oe1, oe2, oe4;
    logic [15:0] rdc1, rdc2, rdc4, wrc1, wrc2, wrc4;
    logic        oob1, oob2, oob4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_bus_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .ram_addr(addr), .ram_be_n(be), .ram_ce_n(ce),
        .ram_oe_n(oe), .ram_we_n(we), .ram_wdata(wdata), .ram_rdata(rdata2),
        .ram_rdata_oe(oe2), .rd_count(rdc2), .wr_count(wrc2), .err_oob(oob2));

    sram_bus_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .ram_addr(addr), .ram_be_n(be), .ram_ce_n(ce),
        .ram_oe_n(oe), .ram_we_n(we), .ram_wdata(wdata), .ram_rdata(rdata1),
        .ram_rdata_oe(oe1), .rd_count(rdc1), .wr_count(wrc1), .err_oob(oob1));

    sram_bus_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(4)) u_lat4 (
        .clk(clk), .reset(reset), .ram_addr(addr), .ram_be_n(be), .ram_ce_n(ce),
        .ram_oe_n(oe), .ram_we_n(we), .ram_wdata(wdata), .ram_rdata(rdata4),
        .ram_rdata_oe(oe4), .rd_count(rdc4), .wr_count(wrc4), .err_oob(oob4));

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ce = 1'b1; oe = 1'b1; we = 1'b1; be = 4'hF;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; oe = 1'b1; ce = 1'b0; we = 1'b0;
        cyc(3);
        bus_idle();
        cyc(3);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] d1,
                      output logic [31:0] d2, output logic [31:0] d4);
        addr = a; we = 1'b1; ce = 1'b0; oe = 1'b0;
        cyc(6);
        d1 = rdata1; d2 = rdata2; d4 = rdata4;
        bus_idle();
        cyc(3);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", rdata2, 32'h0); end
        checks++; if ({oe1, oe2, oe4} !== 3'b000) begin errors++; $display("FAIL reset_oe: got %b want %b", {oe1, oe2, oe4}, 3'b000); end
        checks++; if ({rdc2, wrc2} !== 32'h0) begin errors++; $display("FAIL reset_counts: got %h want %h", {rdc2, wrc2}, 32'h0); end
        checks++; if (oob2 !== 1'b0) begin errors++; $display("FAIL reset_oob: got %b want %b", oob2, 1'b0); end
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_full_word();
        wr(20'h00010, 32'hDEADBEEF, 4'h0);
        addr = 20'h00010; ce = 1'b0; oe = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            checks++; if (oe1 !== (i >= 2)) begin errors++; $display("FAIL lat1_oe cyc%0d: got %b want %b", i, oe1, (i >= 2)); end
            checks++; if (oe2 !== (i >= 3)) begin errors++; $display("FAIL lat2_oe cyc%0d: got %b want %b", i, oe2, (i >= 3)); end
            checks++; if (oe4 !== (i >= 5)) begin errors++; $display("FAIL lat4_oe cyc%0d: got %b want %b", i, oe4, (i >= 5)); end
            if (i >= 5) begin
                checks++; if ({rdata1, rdata2, rdata4} !== {3{32'hDEADBEEF}})
                    begin errors++; $display("FAIL full_word_rdata: got %h %h %h want %h", rdata1, rdata2, rdata4, 32'hDEADBEEF); end
            end
        end
        bus_idle();
        cyc(1);
        checks++; if (oe2 !== 1'b1) begin errors++; $display("FAIL oe_after_drop_sample: got %b want %b", oe2, 1'b1); end
        cyc(1);
        checks++; if (oe2 !== 1'b0) begin errors++; $display("FAIL oe_deassert: got %b want %b", oe2, 1'b0); end
        checks++; if (rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h want %h", rdata2, 32'hDEADBEEF); end
        checks++; if ({wrc2, rdc2} !== {16'd1, 16'd1}) begin errors++; $display("FAIL counts_after_first: got wr=%0d rd=%0d want 1 1", wrc2, rdc2); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] d1, d2, d4;
        wr(20'h00030, 32'h11223344, 4'h0);
        wr(20'h00030, 32'hAABBCCDD, 4'b1010);
        rd(20'h00030, d1, d2, d4);
        checks++; if ({d1, d2, d4} !== {3{32'h11BB33DD}}) begin errors++; $display("FAIL byte_mask: got %h %h %h want %h", d1, d2, d4, 32'h11BB33DD); end
        wr(20'h00030, 32'hFFFFFFFF, 4'hF);
        rd(20'h00030, d1, d2, d4);
        checks++; if (d2 !== 32'h11BB33DD) begin errors++; $display("FAIL be_none_data: got %h want %h", d2, 32'h11BB33DD); end
        checks++; if ({wrc2, rdc2} !== {16'd4, 16'd3}) begin errors++; $display("FAIL be_none_counts: got wr=%0d rd=%0d want 4 3", wrc2, rdc2); end
    endtask

    task automatic test_simul_oe_we();
        addr = 20'h00040; wdata = 32'hCAFEF00D; be = 4'h0; ce = 1'b0; oe = 1'b0; we = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            checks++; if ({oe1, oe2, oe4} !== 3'b000) begin errors++; $display("FAIL simul_oe_in_write cyc%0d: got %b want %b", i, {oe1, oe2, oe4}, 3'b000); end
        end
        we = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            if (i == 2) begin
                checks++; if ({oe1, rdata1} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("FAIL simul_lat1_bypass: got oe=%b %h want 1 %h", oe1, rdata1, 32'hCAFEF00D); end
            end
        end
        checks++; if ({oe1, oe2, oe4} !== 3'b111) begin errors++; $display("FAIL simul_oe_read: got %b want %b", {oe1, oe2, oe4}, 3'b111); end
        checks++; if ({rdata1, rdata2, rdata4} !== {3{32'hCAFEF00D}}) begin errors++; $display("FAIL simul_rdata: got %h %h %h want %h", rdata1, rdata2, rdata4, 32'hCAFEF00D); end
        bus_idle();
        cyc(4);
        checks++; if ({wrc2, rdc2} !== {16'd5, 16'd4}) begin errors++; $display("FAIL simul_counts: got wr=%0d rd=%0d want 5 4", wrc2, rdc2); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d1, d2, d4;
        wr(20'h00000, 32'h600DCAFE, 4'h0);
        checks++; if (oob2 !== 1'b0) begin errors++; $display("FAIL oob_before: got %b want %b", oob2, 1'b0); end
        wr(20'(DEPTH), 32'h12345678, 4'h0);
        checks++; if ({oob1, oob2, oob4} !== 3'b111) begin errors++; $display("FAIL oob_write_flag: got %b want %b", {oob1, oob2, oob4}, 3'b111); end
        checks++; if (wrc2 !== 16'd7) begin errors++; $display("FAIL oob_write_count: got %0d want %0d", wrc2, 7); end
        rd(20'h00000, d1, d2, d4);
        checks++; if ({d1, d2, d4} !== {3{32'h600DCAFE}}) begin errors++; $display("FAIL oob_array_unchanged: got %h %h %h want %h", d1, d2, d4, 32'h600DCAFE); end
        rd(20'(DEPTH + 5), d1, d2, d4);
        checks++; if ({d1, d2, d4} !== 96'h0) begin errors++; $display("FAIL oob_read_zero: got %h %h %h want 0", d1, d2, d4); end
        wr(20'h00001, 32'h00000001, 4'h0);
        checks++; if (oob2 !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b want %b", oob2, 1'b1); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] d1, d2, d4;
        wr(20'h00020, 32'h01020304, 4'h0);
        addr = 20'h00020; wdata = 32'hFFFF0000; be = 4'h0; oe = 1'b1; ce = 1'b0; we = 1'b0;
        cyc(3);
        #2 reset = 1'b1;
        #1;
        checks++; if ({rdata2, oe2, rdc2, wrc2, oob2} !== 66'h0) begin errors++; $display("FAIL reset_mid_write_outputs: got %h %b %h %h %b want 0", rdata2, oe2, rdc2, wrc2, oob2); end
        bus_idle();
        cyc(2);
        reset = 1'b0;
        cyc(1);
        rd(20'h00020, d1, d2, d4);
        checks++; if ({d1, d2, d4} !== {3{32'h01020304}}) begin errors++; $display("FAIL reset_drops_pending: got %h %h %h want %h", d1, d2, d4, 32'h01020304); end
        addr = 20'h00020; ce = 1'b0; oe = 1'b0;
        cyc(5);
        checks++; if (oe2 !== 1'b1) begin errors++; $display("FAIL read_before_reset_oe: got %b want %b", oe2, 1'b1); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({oe1, oe2, oe4, rdata2} !== 35'h0) begin errors++; $display("FAIL reset_mid_read: got oe=%b%b%b rdata=%h want 0", oe1, oe2, oe4, rdata2); end
        bus_idle();
        cyc(2);
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_counter_wrap();
        logic [31:0] d1, d2, d4;
        addr = 20'h00050; be = 4'h0; oe = 1'b1; ce = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            we = 1'b0; wdata = i; cyc(1);
            we = 1'b1; cyc(1);
        end
        bus_idle();
        cyc(3);
        checks++; if (wrc2 !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got %h want %h", wrc2, 16'hFFFF); end
        addr = 20'h00050; be = 4'h0; ce = 1'b0;
        we = 1'b0; wdata = 32'd65535; cyc(1);
        we = 1'b1; cyc(1);
        bus_idle();
        cyc(3);
        checks++; if ({wrc1, wrc2, wrc4} !== 48'h0) begin errors++; $display("FAIL wrap_zero: got %h %h %h want 0", wrc1, wrc2, wrc4); end
        rd(20'h00050, d1, d2, d4);
        checks++; if ({d1, d2, d4} !== {3{32'h0000FFFF}}) begin errors++; $display("FAIL back_to_back_last: got %h %h %h want %h", d1, d2, d4, 32'h0000FFFF); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_byte_mask();
        test_simul_oe_we();
        test_out_of_range();
        test_reset_mid_access();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bus_responder.md
Name: sram_bus_responder

Overview:
- Synthesizable responder for the asynchronous-SRAM style bus that the core arbiter drives toward BaseRAM/ExtRAM (ce_n/oe_n/we_n/be_n/addr/data).
- Backs the bus with an internal word array. Used as an on-FPGA stand-in RAM and as the reference responder in core-level benches.
- Bidirectional data is split into wdata in, rdata out, and rdata_oe. The top-level tristate is built outside this block.

Parameters:
- ADDR_W, 20, bus word-address width.
- DEPTH, 4096, implemented words. Addresses ≥ DEPTH are out of range.
- READ_LAT, 2, cycles from the sampled read strobe to valid rdata. Legal range 1..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ram_addr  in  ADDR_W  word address.
- ram_be_n  in  4  byte enables, active low, bit i = byte i.
- ram_ce_n  in  1  chip select, active low.
- ram_oe_n  in  1  read enable, active low.
- ram_we_n  in  1  write enable, active low.
- ram_wdata  in  32  write data from the initiator.
- ram_rdata  out  32  read data toward the initiator.
- ram_rdata_oe  out  1  drive enable for the external tristate.
- rd_count  out  16  completed reads, wraps.
- wr_count  out  16  committed writes, wraps.
- err_oob  out  1  sticky flag: an out-of-range access occurred.

Behaviour:

Reset values:
- All outputs are 0: ram_rdata, ram_rdata_oe, rd_count, wr_count, err_oob.
- The FSM resets to IDLE.
- Array contents are not reset.

Input sampling:
- Every posedge registers addr, be_n, ce_n, oe_n, we_n and wdata into sample regs (s_*).
- All decisions use s_* only. Inputs are treated as asynchronous to clk, so strobes must be held ≥2 cycles.

FSM states and transitions:
- IDLE:
  - s_ce_n=0 and s_we_n=0 → WRITE.
  - Else s_ce_n=0 and s_oe_n=0 → READ.
  - Else stay in IDLE.
  - Write has priority when oe_n and we_n are both low.
- WRITE:
  - Each cycle, latch addr/be_n/wdata into a pending register. The last low cycle wins.
  - Exit on s_we_n=1 or s_ce_n=1, i.e. the trailing edge.
  - On exit, commit the pending write to the array with byte masking (byte i written iff be_n[i]=0), then increment wr_count.
  - be_n=4'hF commits nothing but still counts.
  - Next state: READ if the exit cycle has ce_n=0, oe_n=0, we_n=1; else IDLE.
- READ:
  - On entry, issue an array read of s_addr.
  - Data is registered through READ_LAT−1 pipeline stages, so ram_rdata is valid READ_LAT cycles after the first sampled strobe cycle.
  - If s_addr changes while in READ, issue a new read. The pipeline keeps flowing and the latest address wins.
  - ram_rdata_oe = READ state delayed by READ_LAT cycles, ANDed with "still in READ". It deasserts the cycle after the strobe drop is sampled, with no extra trailing drive.
  - Exit on s_ce_n=1 or s_oe_n=1, then increment rd_count once per READ visit.
  - s_we_n falling in READ → WRITE immediately. The read counts; any in-flight data is discarded and oe drops.

Out of range (addr ≥ DEPTH):
- Read returns 32'h0.
- Write is dropped, but wr_count still increments.
- err_oob is set and cleared only by reset.

Other rules:
- Counters wrap 16'hFFFF → 0.
- A reset during WRITE drops the pending write. A reset during READ drops oe in the same instant (asynchronous).
- ram_rdata holds its last value when oe is low.

Decomposition:
- Shared package `sram_bus_pkg` holds:
  - FSM state enum {IDLE, READ, WRITE};
  - BE_NONE = 4'hF;
  - the word-width constant 32.
- One natural sub-module: `sram_word_array`, a DEPTH×32 synchronous-read RAM with a 4-bit byte write mask, so it infers block RAM.
- FSM, sampling, read pipeline and counters stay in the top of this block.

Test Plan:
1. Full-word write/readback: write addr 0x00010, wdata 0xDEADBEEF, be_n 0, we_n low for 3 cycles. Then ce_n/oe_n low → ram_rdata=0xDEADBEEF exactly READ_LAT cycles after the first sampled strobe, rdata_oe high, wr_count=1, rd_count=1.
2. Byte masking: preload 0x11223344, write 0xAABBCCDD with be_n=4'b1010 → readback 0x11BB33DD.
3. Simultaneous oe_n=0 and we_n=0: FSM enters WRITE and rdata_oe stays 0 throughout. After we_n rises with oe_n still low → READ, and rdata equals the newly written data.
4. Out of range: write addr DEPTH → err_oob=1, array unchanged. Read addr DEPTH+5 → rdata=0. err_oob stays 1 until reset.
5. Reset mid-write: assert reset during WRITE with addr 0x20 → addr 0x20 retains its old value and all outputs are 0 immediately.
6. Counter wrap: 65536 writes → wr_count=0. READ_LAT=1 and READ_LAT=4 builds each show the latency exactly as specified.
